// File: rtl/int_sqrt_seq.sv
// Sequential radix-2 restoring integer square root: one root bit per clock, start/busy/done handshake.
// Optional round-to-nearest root output when INT_SQRT_ROUND_EN is defined.
module int_sqrt_seq #(
    parameter int W = 16
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic           start,
    input  logic [W-1:0]   X,
    output logic           busy,
    output logic           done,
    output logic [W/2-1:0] root,
    output logic [W/2:0]   rem
);
    localparam int RW  = W / 2;
    localparam int PRW = RW + 2;
    localparam int CW  = (RW > 2) ? $clog2(RW) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state, state_nx;
    logic [W-1:0]    op;
    logic [PRW-1:0]  pr;
    logic [RW-1:0]   proot;
    logic [CW-1:0]   cnt;

    logic [PRW-1:0]  pr_sh, trial, pr_nx;
    logic            ge;
    logic [RW-1:0]   root_load;

`ifdef INT_SQRT_ROUND_EN
    // Remainder above the floor root means X sits past the midpoint (r+0.5)^2.
    function automatic logic [RW-1:0] round_root(input logic [RW-1:0] r,
                                                 input logic [RW:0]   rm);
        if ((rm > {1'b0, r}) && (r != {RW{1'b1}}))
            return r + 1'b1;
        return r;
    endfunction

    assign root_load = round_root(proot, pr[RW:0]);
`else
    assign root_load = proot;
`endif

    assign pr_sh = {pr[PRW-3:0], op[W-1:W-2]};
    assign trial = {proot, 2'b01};
    assign ge    = (pr_sh >= trial);
    assign pr_nx = ge ? (pr_sh - trial) : pr_sh;
    assign busy  = (state == CALC);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = CALC;
            CALC:    if (cnt == '0) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            op    <= '0;
            pr    <= '0;
            proot <= '0;
            cnt   <= '0;
            root  <= '0;
            rem   <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op    <= X;
                        pr    <= '0;
                        proot <= '0;
                        cnt   <= CW'(RW - 1);
                    end
                end
                CALC: begin
                    op    <= {op[W-3:0], 2'b00};
                    pr    <= pr_nx;
                    proot <= {proot[RW-2:0], ge};
                    if (cnt != '0) cnt <= cnt - 1'b1;
                end
                DONE: begin
                    root <= root_load;
                    rem  <= pr[RW:0];
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_int_sqrt_seq.sv
// Directed bench for int_sqrt_seq (W=16 main instance, W=8 secondary instance).
module tb_int_sqrt_seq;
    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        start = 1'b0;
    logic [15:0] X = '0;
    logic        busy, done;
    logic [7:0]  root;
    logic [8:0]  rem;

    logic        start8 = 1'b0;
    logic [7:0]  X8 = '0;
    logic        busy8, done8;
    logic [3:0]  root8;
    logic [4:0]  rem8;

    int n_chk = 0;
    int n_pass = 0;

`ifdef INT_SQRT_ROUND_EN
    localparam int R255 = 16, R241 = 16, R1000 = 32;
`else
    localparam int R255 = 15, R241 = 15, R1000 = 31;
`endif

    int_sqrt_seq #(.W(16)) dut (.Clk(Clk), .Reset(Reset), .start(start), .X(X),
                                .busy(busy), .done(done), .root(root), .rem(rem));
    int_sqrt_seq #(.W(8)) dut8 (.Clk(Clk), .Reset(Reset), .start(start8), .X(X8),
                                .busy(busy8), .done(done8), .root(root8), .rem(rem8));

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int fsqrt(input int x);
        int r = 0;
        while ((r + 1) * (r + 1) <= x) r++;
        return r;
    endfunction

    function automatic int eroot(input int x);
        int r = fsqrt(x);
`ifdef INT_SQRT_ROUND_EN
        if ((x - r * r > r) && (r != 255)) r++;
`endif
        return r;
    endfunction

    function automatic logic [15:0] xv(input int k);
        return 16'(k * 2311 + 100);
    endfunction

    // Launch one operation from IDLE and wait (bounded) for done.
    task automatic run_op(input logic [15:0] x, input int er, input int em, input string tag);
        int lat = 0;
        int bcnt = 0;
        start = 1'b1;
        X = x;
        tick();
        start = 1'b0;
        X = ~x;
        while (!done && lat < 20) begin
            if (busy) bcnt++;
            tick();
            lat++;
        end
        check({tag, "_lat"}, lat, 9);
        check({tag, "_busy"}, bcnt, 8);
        check({tag, "_root"}, root, er);
        check({tag, "_rem"}, rem, em);
    endtask

    initial begin
        int lat;
        int dcnt;
        logic [15:0] rx;

        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_root", root, 0);
        check("rst_rem", rem, 0);
        tick();
        Reset = 1'b1;
        tick();

        run_op(16'd0, 0, 0, "x0");
        tick();
        check("done_pulse", done, 0);
        check("hold_root", root, 0);
        run_op(16'd144, 12, 0, "x144");
        run_op(16'd255, R255, 30, "x255");
        run_op(16'd65535, 255, 510, "x65535");
        run_op(16'd240, 15, 15, "x240");
        run_op(16'd241, R241, 16, "x241");
        tick();
        check("hold_root2", root, R241);
        check("hold_rem2", rem, 16);

        // start held high with X changing every cycle: accepts at edges 0, 10, 20.
        start = 1'b1;
        for (int k = 0; k <= 20; k++) begin
            X = xv(k);
            tick();
            if (k == 8)  check("b2b_nodone", done, 0);
            if (k == 9) begin
                check("b2b0_done", done, 1);
                check("b2b0_root", root, eroot(xv(0)));
                check("b2b0_rem", rem, xv(0) - fsqrt(xv(0)) * fsqrt(xv(0)));
            end
            if (k == 19) begin
                check("b2b1_done", done, 1);
                check("b2b1_root", root, eroot(xv(10)));
                check("b2b1_rem", rem, xv(10) - fsqrt(xv(10)) * fsqrt(xv(10)));
            end
        end
        start = 1'b0;
        lat = 0;
        while (!done && lat < 20) begin
            tick();
            lat++;
        end
        check("b2b2_lat", lat, 9);
        check("b2b2_root", root, eroot(xv(20)));

        // Reset during the 4th CALC cycle of X=1000.
        tick();
        start = 1'b1;
        X = 16'd1000;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        #2 Reset = 1'b0;
        #1;
        check("abort_root", root, 0);
        check("abort_rem", rem, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        tick();
        Reset = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) dcnt++;
            tick();
        end
        check("abort_nodone", dcnt, 0);
        run_op(16'd1000, R1000, 39, "x1000");

        // Random model comparison.
        for (int i = 0; i < 1000; i++) begin
            rx = 16'($urandom);
            start = 1'b1;
            X = rx;
            tick();
            start = 1'b0;
            lat = 0;
            while (!done && lat < 20) begin
                tick();
                lat++;
            end
            check("rnd_root", root, eroot(rx));
            check("rnd_inv", fsqrt(rx) * fsqrt(rx) + rem, rx);
        end

        // W=8 instance.
        start8 = 1'b1;
        X8 = 8'd200;
        tick();
        start8 = 1'b0;
        X8 = 8'd7;
        lat = 0;
        while (!done8 && lat < 12) begin
            tick();
            lat++;
        end
        check("w8_lat", lat, 5);
        check("w8_root", root8, 14);
        check("w8_rem", rem8, 4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
